// File: rtl/mod_wavebank.sv
// rtl/mod_wavebank.sv - multi-channel oscillator bank (sine/square/saw/triangle) with frame-atomic output
//
// Purpose: on each i_trigger pulse, computes one sample per channel from that
// channel's phase accumulator, then advances the accumulator. All channels
// share one CORDIC datapath and are processed one after another. The finished
// frame is copied to o_sample in a single cycle.
//
// Ports:
//   i_clk        - clock; all logic runs on its rising edge
//   i_rst        - synchronous active-high reset
//   i_trigger    - one-cycle pulse that requests a sample frame
//   i_freq       - per-channel phase increment, channel k at [k*PHASE_W +: PHASE_W]
//   i_wave       - per-channel waveform: 0 sine, 1 square, 2 saw, 3 triangle
//   i_enable     - per-channel enable
//   i_phase_clr  - per-channel phase zero request, captured with i_trigger
//   o_sample     - registered signed samples, channel k at [k*OUT_W +: OUT_W]
//   o_ready      - one-cycle pulse: a new o_sample frame is valid
//   o_busy       - high while a frame is being computed
//   o_overrun    - one-cycle pulse: a trigger arrived while busy and was dropped
module mod_wavebank #(
    parameter int CHANNELS = 4,
    parameter int OUT_W    = 24,
    parameter int PHASE_W  = 32,
    parameter int ITERS    = 20
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_trigger,
    input  logic [CHANNELS*PHASE_W-1:0] i_freq,
    input  logic [CHANNELS*2-1:0]       i_wave,
    input  logic [CHANNELS-1:0]         i_enable,
    input  logic [CHANNELS-1:0]         i_phase_clr,
    output logic [CHANNELS*OUT_W-1:0]   o_sample,
    output logic                        o_ready,
    output logic                        o_busy,
    output logic                        o_overrun
);

    localparam int KW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CW = $clog2(ITERS + 1);
    // Guard bits below the output LSB keep CORDIC rounding error small.
    localparam int G  = 4;
    localparam int XW = OUT_W + G + 2;

    localparam logic [OUT_W-1:0]        MAX_O   = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]        NEG_MAX = {1'b1, {(OUT_W-2){1'b0}}, 1'b1};
    localparam logic signed [XW-1:0]    MAX_X   = signed'({{(XW-OUT_W){1'b0}}, MAX_O});
    localparam logic signed [XW-1:0]    HALF    = XW'(1 << (G-1));
    // Start vector x0 = K * MAX * 2^G with K = 0.60725293 (CORDIC gain inverse,
    // 652032875 = K * 2^30), so the final y needs no gain correction.
    localparam logic [OUT_W+33:0]       X0_WIDE = {34'd0, MAX_O} * (OUT_W+34)'(652032875);
    localparam logic signed [XW-1:0]    X0      = signed'(X0_WIDE[30-G +: XW]);

    typedef enum logic [2:0] {IDLE, LOAD, ITER, WRITE, DONE} state_t;

    state_t                      state, state_nx;
    logic [KW-1:0]               k;
    logic [CW-1:0]               cnt;
    logic [CHANNELS*PHASE_W-1:0] freq_sh;
    logic [CHANNELS*2-1:0]       wave_sh;
    logic [CHANNELS-1:0]         en_sh, clr_sh;
    logic [PHASE_W-1:0]          phase   [CHANNELS];
    logic [OUT_W-1:0]            scratch [CHANNELS];
    logic [OUT_W:0]              p_top;
    logic signed [XW-1:0]        cx, cy;
    logic signed [PHASE_W-1:0]   cz;
    logic                        flip;

    // atan(2^-i) in units where 2^32 is one full turn, rescaled to PHASE_W.
    function automatic logic [PHASE_W-1:0] atan_tab(input logic [CW-1:0] i);
        logic [31:0] a;
        case (int'(i))
            0:  a = 32'h2000_0000;  1:  a = 32'h12E4_051E;
            2:  a = 32'h09FB_385B;  3:  a = 32'h0511_11D4;
            4:  a = 32'h028B_0D43;  5:  a = 32'h0145_D7E1;
            6:  a = 32'h00A2_F61E;  7:  a = 32'h0051_7C55;
            8:  a = 32'h0028_BE53;  9:  a = 32'h0014_5F2F;
            10: a = 32'h000A_2F98;  11: a = 32'h0005_17CC;
            12: a = 32'h0002_8BE6;  13: a = 32'h0001_45F3;
            14: a = 32'h0000_A2FA;  15: a = 32'h0000_517D;
            16: a = 32'h0000_28BE;  17: a = 32'h0000_145F;
            18: a = 32'h0000_0A30;  19: a = 32'h0000_0518;
            20: a = 32'h0000_028C;  21: a = 32'h0000_0146;
            22: a = 32'h0000_00A3;  23: a = 32'h0000_0051;
            24: a = 32'h0000_0029;  25: a = 32'h0000_0014;
            26: a = 32'h0000_000A;  27: a = 32'h0000_0005;
            28: a = 32'h0000_0003;  29: a = 32'h0000_0001;
            30: a = 32'h0000_0001;
            default: a = 32'h0000_0000;
        endcase
        return PHASE_W'({a, {PHASE_W{1'b0}}} >> 32);
    endfunction

    // Current-channel view of the captured configuration.
    logic [PHASE_W-1:0] freq_k, p_load;
    logic [1:0]         wave_k;
    logic               en_k, clr_k, flip_load;
    logic signed [PHASE_W-1:0] z_load, atan_i;
    logic signed [XW-1:0]      cx_sh, cy_sh, y_rnd, y_sat;
    logic [OUT_W-1:0]          tri_x, sample_k;

    always_comb begin
        freq_k    = freq_sh[k*PHASE_W +: PHASE_W];
        wave_k    = wave_sh[k*2 +: 2];
        en_k      = en_sh[k];
        clr_k     = clr_sh[k];
        p_load    = clr_k ? '0 : phase[k];
        // Quadrants 01 and 10 are folded by pi (flip the MSB) and the result
        // negated; the folded angle equals the lower bits sign-extended.
        flip_load = p_load[PHASE_W-1] ^ p_load[PHASE_W-2];
        z_load    = signed'({p_load[PHASE_W-2], p_load[PHASE_W-2:0]});
        atan_i    = signed'(atan_tab(cnt));
        cx_sh     = cx >>> cnt;
        cy_sh     = cy >>> cnt;
    end

    always_comb begin
        y_rnd = (cy + HALF) >>> G;
        y_sat = y_rnd;
        if (y_rnd > MAX_X)
            y_sat = MAX_X;
        else if (y_rnd < -MAX_X)
            y_sat = -MAX_X;
        tri_x = p_top[OUT_W] ? ~p_top[OUT_W-1:0] : p_top[OUT_W-1:0];
        sample_k = '0;
        if (en_k) begin
            case (wave_k)
                2'd0:    sample_k = OUT_W'(flip ? -y_sat : y_sat);
                2'd1:    sample_k = p_top[OUT_W] ? NEG_MAX : MAX_O;
                2'd2:    sample_k = {~p_top[OUT_W], p_top[OUT_W-1:1]};
                default: sample_k = {~tri_x[OUT_W-1], tri_x[OUT_W-2:0]};
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (i_trigger) state_nx = LOAD;
            LOAD:    state_nx = (wave_k == 2'd0 && en_k) ? ITER : WRITE;
            ITER:    if (cnt == CW'(ITERS-1)) state_nx = WRITE;
            WRITE:   state_nx = (k == KW'(CHANNELS-1)) ? DONE : LOAD;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign o_busy = (state != IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int j = 0; j < CHANNELS; j++) begin
                phase[j]   <= '0;
                scratch[j] <= '0;
            end
            o_sample  <= '0;
            o_ready   <= 1'b0;
            o_overrun <= 1'b0;
            k         <= '0;
            cnt       <= '0;
            freq_sh   <= '0;
            wave_sh   <= '0;
            en_sh     <= '0;
            clr_sh    <= '0;
            p_top     <= '0;
            cx        <= '0;
            cy        <= '0;
            cz        <= '0;
            flip      <= 1'b0;
        end else begin
            o_ready   <= 1'b0;
            // Any trigger outside IDLE (including DONE) is dropped and flagged.
            o_overrun <= i_trigger && (state != IDLE);
            case (state)
                IDLE: begin
                    if (i_trigger) begin
                        freq_sh <= i_freq;
                        wave_sh <= i_wave;
                        en_sh   <= i_enable;
                        clr_sh  <= i_phase_clr;
                        k       <= '0;
                    end
                end
                LOAD: begin
                    phase[k] <= en_k ? p_load + freq_k : p_load;
                    p_top    <= p_load[PHASE_W-1 -: OUT_W+1];
                    flip     <= flip_load;
                    cx       <= X0;
                    cy       <= '0;
                    cz       <= z_load;
                    cnt      <= '0;
                end
                ITER: begin
                    if (!cz[PHASE_W-1]) begin
                        cx <= cx - cy_sh;
                        cy <= cy + cx_sh;
                        cz <= cz - atan_i;
                    end else begin
                        cx <= cx + cy_sh;
                        cy <= cy - cx_sh;
                        cz <= cz + atan_i;
                    end
                    cnt <= cnt + 1'b1;
                end
                WRITE: begin
                    scratch[k] <= sample_k;
                    if (k != KW'(CHANNELS-1))
                        k <= k + 1'b1;
                end
                DONE: begin
                    for (int j = 0; j < CHANNELS; j++)
                        o_sample[j*OUT_W +: OUT_W] <= scratch[j];
                    o_ready <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
